// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx
// Brief    : Memory-mapped 8N1 serial transmitter with a small byte FIFO,
//            edge-detected send / clear-overflow strobes and a pollable
//            status byte.
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA_IN,
    input  logic [7:0] CTRL_IN,
    output logic       TXD,
    output logic [7:0] STATUS
);

    localparam int              c_PTR_W    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0]      c_DEPTH    = 3'(FIFO_DEPTH);
    localparam logic [15:0]     c_BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [15:0]          r_bit_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_txd;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [2:0]           r_count;
    logic                 r_overflow;
    logic [1:0]           r_ctrl_prev;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_bit_end;
    logic                 w_push_req;
    logic                 w_clr_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_unused_ctrl;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == 3'd0);
    assign w_bit_end  = (r_bit_cnt == c_BIT_LAST);
    assign w_push_req = CTRL_IN[0] & ~r_ctrl_prev[0];
    assign w_clr_req  = CTRL_IN[1] & ~r_ctrl_prev[1];
    // A full FIFO drops the byte even if the FSM frees a slot on this edge.
    assign w_push     = w_push_req & ~w_full;
    // The FSM takes the head byte from IDLE, or at the end of a stop bit for
    // back-to-back frames.
    assign w_pop      = ~w_empty & ((r_state == S_IDLE) |
                                    ((r_state == S_STOP) & w_bit_end));
    assign w_unused_ctrl = ^CTRL_IN[7:2];

    assign TXD    = r_txd;
    assign STATUS = {1'b0, r_count, r_overflow, w_empty, w_full,
                     (r_state != S_IDLE)};

    // FIFO storage: written only on an accepted push, no reset needed.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DATA_IN;
        end
    end

    // Strobe history, FIFO pointers/count and the sticky overflow flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ctrl_prev <= 2'b00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= 3'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_ctrl_prev <= CTRL_IN[1:0];
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            // A dropped push on the same edge as a clear leaves the flag set.
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr_req) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd     <= 1'b1;
                    r_bit_cnt <= 16'd0;
                    if (!w_empty) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_txd     <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 16'd0;
                        if (!w_empty) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_txd   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_tx
// Brief    : Self-checking bench for io_uart_tx (CLKS_PER_BIT=4, depth 4).
//            Accepted bytes go into a scoreboard queue; a line monitor
//            decodes frames on TXD and compares against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

    localparam int c_CPB   = 4;
    localparam int c_DEPTH = 4;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic [7:0] CTRL_IN;
    logic       TXD;
    logic [7:0] STATUS;

    int         n_vec;
    int         n_err;
    int         cyc;
    bit         mon_en;
    bit         in_frame;
    logic [7:0] sb [$];
    int         starts [$];

    io_uart_tx #(
        .CLKS_PER_BIT (c_CPB),
        .FIFO_DEPTH   (c_DEPTH)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .DATA_IN (DATA_IN),
        .CTRL_IN (CTRL_IN),
        .TXD     (TXD),
        .STATUS  (STATUS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One-cycle send strobe; returns at the negedge just after the sampling edge.
    task automatic push_byte(input logic [7:0] b, input bit accepted);
        @(negedge CLK);
        DATA_IN    = b;
        CTRL_IN[0] = 1'b1;
        if (accepted) sb.push_back(b);
        @(negedge CLK);
        CTRL_IN[0] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge CLK);
            done = (sb.size() == 0) && !in_frame && (STATUS == 8'h04);
        end
        check(tag, done, 1'b1);
        repeat (50) @(negedge CLK);
        check({tag, "_idle_txd"}, TXD, 1'b1);
    endtask

    // Line monitor: samples each bit mid-cell on the falling clock edge.
    initial begin
        logic [7:0] data;
        logic [7:0] exp;
        in_frame = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en && RESET && TXD == 1'b0) begin
                in_frame = 1'b1;
                starts.push_back(cyc);
                repeat (2) @(negedge CLK);
                check("start_bit", TXD, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_CPB) @(negedge CLK);
                    data[i] = TXD;
                    check("busy_in_frame", STATUS[0], 1'b1);
                end
                repeat (c_CPB) @(negedge CLK);
                check("stop_bit", TXD, 1'b1);
                check("frame_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    check("frame_data", data, exp);
                end
                @(negedge CLK);
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        int busy_cycles;
        n_vec   = 0;
        n_err   = 0;
        cyc     = 0;
        mon_en  = 1'b0;
        RESET   = 1'b0;
        DATA_IN = 8'h00;
        CTRL_IN = 8'h00;

        // 1. reset values, hold after release, then reset mid-frame
        repeat (3) @(negedge CLK);
        check("rst_txd", TXD, 1'b1);
        check("rst_status", STATUS, 8'h04);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        check("post_rst_txd", TXD, 1'b1);
        check("post_rst_status", STATUS, 8'h04);
        push_byte(8'h55, 1'b0);
        push_byte(8'h66, 1'b0);
        repeat (10) @(negedge CLK);
        check("midframe_busy", STATUS[0], 1'b1);
        RESET = 1'b0;
        #1;
        check("async_rst_txd", TXD, 1'b1);
        check("async_rst_status", STATUS, 8'h04);
        @(negedge CLK);
        RESET = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || STATUS !== 8'h04) busy_cycles++;
        end
        check("rst_hold_cycles_bad", busy_cycles, 0);
        mon_en = 1'b1;

        // 2. single byte: latency and 40-cycle busy window
        @(negedge CLK);
        DATA_IN = 8'hA5;
        CTRL_IN[0] = 1'b1;
        sb.push_back(8'hA5);
        @(negedge CLK);
        CTRL_IN[0] = 1'b0;
        check("lat_txd_n", TXD, 1'b1);
        check("lat_status_n", STATUS, 8'h10);
        @(negedge CLK);
        check("lat_txd_n1", TXD, 1'b0);
        check("lat_status_n1", STATUS, 8'h05);
        busy_cycles = 1;
        for (int i = 0; i < 100 && STATUS[0]; i++) begin
            @(negedge CLK);
            if (STATUS[0]) busy_cycles++;
        end
        check("busy_len", busy_cycles, 10 * c_CPB);
        check("single_end_status", STATUS, 8'h04);
        wait_drain("drain_single");

        // 3. held strobe sends exactly one byte
        @(negedge CLK);
        DATA_IN = 8'h3C;
        CTRL_IN[0] = 1'b1;
        sb.push_back(8'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("held_cnt_le1", STATUS[6:4] <= 3'd1, 1'b1);
        end
        CTRL_IN[0] = 1'b0;
        wait_drain("drain_held");

        // 4. back-to-back frames with no idle gap
        starts.delete();
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        check("b2b_cnt", STATUS[6:4], 3'd2);
        wait_drain("drain_b2b");
        check("b2b_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("b2b_gap1", starts[1] - starts[0], 10 * c_CPB);
            check("b2b_gap2", starts[2] - starts[1], 10 * c_CPB);
        end

        // 5. overflow, simultaneous push+clear while full, then clear
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h12, 1'b1);
        push_byte(8'h13, 1'b1);
        push_byte(8'h14, 1'b1);
        check("full_status", STATUS, 8'h4B - 8'h08);
        push_byte(8'h15, 1'b0);
        check("ovf_status", STATUS, 8'h4B);
        @(negedge CLK);
        DATA_IN = 8'h16;
        CTRL_IN = 8'h03;
        @(negedge CLK);
        CTRL_IN = 8'h00;
        check("push_clr_same_edge", STATUS, 8'h4B);
        @(negedge CLK);
        CTRL_IN = 8'h02;
        @(negedge CLK);
        CTRL_IN = 8'h00;
        check("ovf_cleared", STATUS, 8'h43);
        wait_drain("drain_ovf");

        // 6. push on the same edge the FSM pops a 1-entry FIFO (stop end)
        push_byte(8'hC1, 1'b1);
        push_byte(8'hC2, 1'b1);
        check("sim_cnt_before", STATUS[6:4], 3'd1);
        repeat (38) @(negedge CLK);
        DATA_IN = 8'hC3;
        CTRL_IN[0] = 1'b1;
        sb.push_back(8'hC3);
        @(negedge CLK);
        CTRL_IN[0] = 1'b0;
        check("sim_cnt_after", STATUS[6:4], 3'd1);
        check("sim_busy", STATUS[0], 1'b1);
        check("sim_new_start", TXD, 1'b0);
        wait_drain("drain_sim");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
